// File: rtl/my_mc14495_pkg.sv
// Shared definitions for the MC14495-style hex decoder: segment vector type
// ordered {a,b,c,d,e,f,g} and the active-low patterns for digits 0..F.
package my_mc14495_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble to active-low seven-segment pattern, {a..g} order.
module hex7seg_decode
  import my_mc14495_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/my_mc14495.sv
// Registered hex-to-seven-segment driver with blanking and decimal point.
// Decimal point lane is present only when MY_MC14495_POINT_EN is defined.
module my_mc14495
  import my_mc14495_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic D3,
  input  logic D2,
  input  logic D1,
  input  logic D0,
  input  logic LE,
  input  logic point,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic P
);

  seg_t seg_dec;
  seg_t seg_q;
  logic p_q;

  hex7seg_decode u_decode (
    .nibble ({D3, D2, D1, D0}),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
    end else begin
      seg_q <= LE ? SEG_BLANK : seg_dec;
    end
  end

`ifdef MY_MC14495_POINT_EN
  // Point lane ignores LE: blanking only darkens a..g.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q <= 1'b1;
    end else begin
      p_q <= ~point;
    end
  end
`else
  logic unused_point;
  assign unused_point = point;
  assign p_q = 1'b1;
`endif

  assign {a, b, c, d, e, f, g} = seg_q;
  assign P = p_q;

endmodule

// File: tb/tb_my_mc14495.sv
// Self-checking bench for my_mc14495: directed steps then randomized cycles
// against a lookup-table reference of the published segment patterns.
module tb_my_mc14495;

  logic clk = 1'b0;
  logic rst_n, D3, D2, D1, D0, LE, point;
  logic a, b, c, d, e, f, g, P;

  int tests = 0;
  int failed = 0;

  logic [6:0] tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic [6:0] exp_seg;
  logic       exp_p;

  my_mc14495 dut (
    .clk(clk), .rst_n(rst_n),
    .D3(D3), .D2(D2), .D1(D1), .D0(D0),
    .LE(LE), .point(point),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .P(P)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] es, input logic ep);
    tests++;
    assert ({a, b, c, d, e, f, g} === es)
    else begin
      failed++;
      $error("FAIL %s seg got %b expected %b", tag, {a, b, c, d, e, f, g}, es);
    end
    tests++;
    assert (P === ep)
    else begin
      failed++;
      $error("FAIL %s P got %b expected %b", tag, P, ep);
    end
  endtask

  // Drive inputs, predict the registered result, clock once, then check.
  task automatic step(input string tag, input logic rst, input logic [3:0] n,
                      input logic le, input logic pt);
    rst_n = rst;
    {D3, D2, D1, D0} = n;
    LE = le;
    point = pt;
    if (!rst) begin
      exp_seg = 7'h7F;
      exp_p   = 1'b1;
    end else begin
      exp_seg = le ? 7'h7F : tbl[n];
`ifdef MY_MC14495_POINT_EN
      exp_p = ~pt;
`else
      exp_p = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    check(tag, exp_seg, exp_p);
  endtask

  initial begin
    logic [3:0] rn;
    logic rr, rl, rp;
    rst_n = 1'b0; {D3, D2, D1, D0} = 4'h0; LE = 1'b0; point = 1'b0;

    step("reset1", 1'b0, 4'h8, 1'b0, 1'b1);
    step("reset2", 1'b0, 4'h8, 1'b0, 1'b1);
    step("release", 1'b1, 4'h8, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      step($sformatf("sweep%0d", i), 1'b1, iv, 1'b0, iv[0]);
    end

    step("blank", 1'b1, 4'h3, 1'b1, 1'b1);
    step("unblank", 1'b1, 4'h3, 1'b0, 1'b1);

    step("lat5", 1'b1, 4'h5, 1'b0, 1'b0);
    {D3, D2, D1, D0} = 4'h6;
    #3;
    check("lat_hold", exp_seg, exp_p);
    exp_seg = tbl[6];
    @(posedge clk);
    #1;
    check("lat6", exp_seg, exp_p);

    step("mid_run", 1'b1, 4'hA, 1'b0, 1'b0);
    step("mid_rst", 1'b0, 4'hA, 1'b0, 1'b0);
    step("mid_rel", 1'b1, 4'hA, 1'b0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      rn = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 15) != 0);
      rl = ($urandom_range(0, 3) == 0);
      rp = 1'($urandom_range(0, 1));
      step($sformatf("rand%0d", k), rr, rn, rl, rp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/my_mc14495.md
# my_mc14495

Registered hexadecimal-to-seven-segment decoder, functionally equivalent to the MC14495 with a decimal-point lane and a blanking input. It accepts a 4-bit nibble plus a point request and drives active-low segment lines (common-anode display) for one digit. It sits between the digit-select/scan logic and the board-level segment pins.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- D3  input  1  nibble bit 3 (MSB)
- D2  input  1  nibble bit 2
- D1  input  1  nibble bit 1
- D0  input  1  nibble bit 0 (LSB)
- LE  input  1  blank enable, active-high; 1 turns all segments a..g off
- point  input  1  decimal-point request, active-high
- a, b, c, d, e, f, g  output  1 each  segment drives, active-low (0 = lit)
- P  output  1  decimal-point drive, active-low

## Operation
- Nibble N = {D3,D2,D1,D0}, 0..15.
- Active-low patterns {a,b,c,d,e,f,g}: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- LE=1: a..g all 1 regardless of N.
- P = ~point. P is independent of LE and N.
- No X-propagation special-casing; all 16 codes are defined, so no illegal input exists.

## Timing
- All outputs registered; one clk latency from inputs to outputs.
- At a rising edge with rst_n=0: a..g = 1, P = 1 (display dark). Holds until first edge with rst_n=1.
- At a rising edge with rst_n=1: outputs load the decode of the inputs present at that edge.
- Reset deasserted mid-stream: first edge with rst_n=1 loads current inputs; no extra warm-up cycle.
- LE and point changing on the same edge as N: all three take effect together on that edge.
- Outputs change only on rising clk edges; no combinational path from inputs to outputs.

## Configuration
- MY_MC14495_POINT_EN defined: P register driven as above.
- Not defined: point input ignored, P constant 1 (decimal point always off), including after reset.

## Structure
- Shared package my_mc14495_pkg: 7-bit segment-pattern constants for digits 0..F, SEG_BLANK (7'b1111111), and a segment-vector typedef ordered {a..g}.
- One combinational sub-module hex7seg_decode (4-bit nibble in, 7-bit active-low pattern out); top adds LE blanking, point inversion, and the output register stage.

## Test plan
- Reset: rst_n=0 for 2 edges with N=8, LE=0, point=1 -> a..g=1, P=1; release -> next edge a..g=0000000, P=0.
- Full sweep: LE=0, N and point set to i and i[0] for i=0..15, one per cycle -> each pattern matches the list one edge later; P alternates 1,0,1,0,...
- Blanking: N=3, point=1, LE=1 -> a..g=1111111, P=0; drop LE -> next edge 0000110.
- Latency: change N 5->6 between edges -> outputs stay 0100100 until the next rising edge, then 0100000.
- Mid-stream reset: N=A, LE=0 running; assert rst_n=0 one edge -> outputs 1111111, P=1 on that edge; release -> 0001000.
- Macro off: build without MY_MC14495_POINT_EN, toggle point -> P stays 1; segments unaffected.
